// File: rtl/key_seq_tx.sv
// Serial transmitter for the unlock-key link: sends KEY_PATTERN MSB first, then a mode bit,
// then forwards single-bit mode updates. Define KEY_SEQ_TX_GAP_EN to insert GAP_CYCLES idle cycles between beats.
module key_seq_tx #(
  parameter logic [3:0] KEY_PATTERN = 4'b1010,
  parameter int         GAP_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic req_mode,
  input  logic upd,
  input  logic upd_mode,
  output logic key_out,
  output logic valid_cmd,
  output logic busy,
  output logic link_up,
  output logic mode_shadow,
  output logic upd_ready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEY    = 3'd1;
  localparam logic [2:0] S_MODE   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_ACTIVE = 3'd4;
  localparam logic [2:0] S_UPD    = 3'd5;

  logic [2:0] state_reg;
  logic [1:0] idx_reg;
  logic       mode_cap_reg;

`ifdef KEY_SEQ_TX_GAP_EN
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);
  logic [3:0] gap_cnt_reg;
  logic [2:0] pend_reg;
`endif

  gap_range: assert property (@(posedge clk) disable iff (reset)
    (GAP_CYCLES >= 1 && GAP_CYCLES <= 15));

  // Outputs are registered from the current state, so each beat appears one edge after
  // the state that produces it; every non-beat cycle forces valid_cmd/key_out low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 2'd3;
      mode_cap_reg <= 1'b0;
      key_out      <= 1'b0;
      valid_cmd    <= 1'b0;
      busy         <= 1'b0;
      link_up      <= 1'b0;
      mode_shadow  <= 1'b0;
      upd_ready    <= 1'b0;
`ifdef KEY_SEQ_TX_GAP_EN
      gap_cnt_reg  <= 4'd0;
      pend_reg     <= S_IDLE;
`endif
    end else begin
      key_out   <= 1'b0;
      valid_cmd <= 1'b0;
      busy      <= 1'b0;
      upd_ready <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            mode_cap_reg <= req_mode;
            idx_reg      <= 2'd3;
            state_reg    <= S_KEY;
          end
        end
        S_KEY: begin
          valid_cmd <= 1'b1;
          key_out   <= KEY_PATTERN[idx_reg];
          busy      <= 1'b1;
          if (idx_reg != 2'd0) begin
            idx_reg <= idx_reg - 2'd1;
`ifdef KEY_SEQ_TX_GAP_EN
            gap_cnt_reg <= GAP_LOAD;
            pend_reg    <= S_KEY;
            state_reg   <= S_GAP;
`endif
          end else begin
`ifdef KEY_SEQ_TX_GAP_EN
            gap_cnt_reg <= GAP_LOAD;
            pend_reg    <= S_MODE;
            state_reg   <= S_GAP;
`else
            state_reg   <= S_MODE;
`endif
          end
        end
        S_MODE: begin
          valid_cmd   <= 1'b1;
          key_out     <= mode_cap_reg;
          mode_shadow <= mode_cap_reg;
          busy        <= 1'b1;
          state_reg   <= S_ACTIVE;
        end
`ifdef KEY_SEQ_TX_GAP_EN
        S_GAP: begin
          // busy only covers gaps inside the unlock sequence, not after updates
          busy <= ~link_up;
          if (gap_cnt_reg <= 4'd1) begin
            state_reg <= pend_reg;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 4'd1;
          end
        end
`endif
        S_ACTIVE: begin
          link_up <= 1'b1;
          // upd_ready drops on the accepting edge so a back-to-back upd is dropped
          if (upd && upd_ready) begin
            mode_cap_reg <= upd_mode;
            state_reg    <= S_UPD;
          end else begin
            upd_ready <= 1'b1;
          end
        end
        S_UPD: begin
          valid_cmd   <= 1'b1;
          key_out     <= mode_cap_reg;
          mode_shadow <= mode_cap_reg;
`ifdef KEY_SEQ_TX_GAP_EN
          gap_cnt_reg <= GAP_LOAD;
          pend_reg    <= S_ACTIVE;
          state_reg   <= S_GAP;
`else
          state_reg   <= S_ACTIVE;
`endif
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_seq_tx.sv
// Scoreboard bench for key_seq_tx: stimulus pushes expected beats (bit + cycle), a monitor
// pops and compares every valid_cmd beat; a small decoder model checks the link outcome.
module tb_key_seq_tx;

  localparam logic [3:0] KEY = 4'b1010;
`ifdef KEY_SEQ_TX_GAP_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, req_mode = 1'b0, upd = 1'b0, upd_mode = 1'b0;
  logic key_out, valid_cmd, busy, link_up, mode_shadow, upd_ready;

  key_seq_tx #(.KEY_PATTERN(KEY), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .req_mode(req_mode),
    .upd(upd), .upd_mode(upd_mode), .key_out(key_out), .valid_cmd(valid_cmd),
    .busy(busy), .link_up(link_up), .mode_shadow(mode_shadow), .upd_ready(upd_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic b; int cyc; } beat_t;
  beat_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Decoder model: 4 matching key bits, then a mode bit activates it; later beats set mode.
  int  dec_cnt;
  logic dec_active, dec_mode;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt <= 0; dec_active <= 1'b0; dec_mode <= 1'b0;
    end else if (valid_cmd) begin
      if (dec_active) dec_mode <= key_out;
      else if (dec_cnt == 4) begin
        dec_active <= 1'b1; dec_mode <= key_out;
      end else if (key_out == KEY[3 - dec_cnt]) dec_cnt <= dec_cnt + 1;
      else dec_cnt <= 0;
    end
  end

  // Monitor: every beat must match the head of the scoreboard, at the expected cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_cmd) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_beat: got key_out %0d with empty queue (cycle %0d)", key_out, cyc);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_bit", {31'd0, key_out}, {31'd0, e.b});
          check("beat_cycle", cyc, e.cyc);
        end
      end else if (key_out !== 1'b0) begin
        compared++; mismatched++;
        $display("FAIL idle_key_out: got %0d expected 0 (cycle %0d)", key_out, cyc);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_seq(input logic m, input int n_beats, output int e0);
    beat_t b;
    @(negedge clk);
    start = 1'b1; req_mode = m;
    e0 = cyc + 1;
    for (int i = 0; i < n_beats; i++) begin
      b.b = (i < 4) ? KEY[3 - i] : m;
      b.cyc = e0 + 1 + i * (G + 1);
      exp_q.push_back(b);
    end
    @(negedge clk);
    start = 1'b0; req_mode = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_out"}, {31'd0, key_out}, 0);
    check({tag, "_valid_cmd"}, {31'd0, valid_cmd}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_link_up"}, {31'd0, link_up}, 0);
    check({tag, "_mode_shadow"}, {31'd0, mode_shadow}, 0);
    check({tag, "_upd_ready"}, {31'd0, upd_ready}, 0);
  endtask

  task automatic send_upd(input logic m, output int n);
    @(negedge clk);
    upd = 1'b1; upd_mode = m;
    n = cyc + 1;
  endtask

  initial begin
    int e0, n;
    beat_t b;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // upd in IDLE is ignored
    @(negedge clk); upd = 1'b1; upd_mode = 1'b1;
    repeat (2) @(negedge clk);
    upd = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_upd_busy", {31'd0, busy}, 0);
    check("idle_upd_shadow", {31'd0, mode_shadow}, 0);

    // full unlock with mode 1, plus a start pulse while in KEY
    start_seq(1'b1, 5, e0);
    check("busy_before_beats", {31'd0, busy}, 0);
    @(negedge clk);
    check("busy_first_beat", {31'd0, busy}, 1);
    start = 1'b1; req_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_until(e0 + 5 + 4 * G);
    check("busy_mode_beat", {31'd0, busy}, 1);
    check("link_up_early", {31'd0, link_up}, 0);
    wait_until(e0 + 6 + 4 * G);
    check("link_up", {31'd0, link_up}, 1);
    check("upd_ready", {31'd0, upd_ready}, 1);
    check("busy_done", {31'd0, busy}, 0);
    check("mode_shadow_1", {31'd0, mode_shadow}, 1);
    check("dec_active", {31'd0, dec_active}, 1);
    check("dec_mode_1", {31'd0, dec_mode}, 1);

    // start in ACTIVE is ignored
    @(negedge clk); start = 1'b1; req_mode = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("active_start_link", {31'd0, link_up}, 1);
    check("active_start_busy", {31'd0, busy}, 0);

    // back-to-back updates: first accepted, second dropped
    send_upd(1'b1, n);
    b.b = 1'b1; b.cyc = n + 1; exp_q.push_back(b);
    @(negedge clk);
    check("upd_ready_drop", {31'd0, upd_ready}, 0);
    upd = 1'b1; upd_mode = 1'b0;
    @(negedge clk);
    upd = 1'b0;
    check("upd_shadow_1", {31'd0, mode_shadow}, 1);
    wait_until(n + 1 + G);
    check("upd_ready_low", {31'd0, upd_ready}, 0);
    wait_until(n + 2 + G);
    check("upd_ready_back", {31'd0, upd_ready}, 1);
    repeat (4) @(negedge clk);
    check("upd_dropped_shadow", {31'd0, mode_shadow}, 1);

    // a later update to 0 is accepted
    send_upd(1'b0, n);
    b.b = 1'b0; b.cyc = n + 1; exp_q.push_back(b);
    @(negedge clk); upd = 1'b0;
    repeat (G + 3) @(negedge clk);
    check("upd_shadow_0", {31'd0, mode_shadow}, 0);
    check("dec_mode_0", {31'd0, dec_mode}, 0);

    // reset after the third key beat, then replay from bit 3
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_seq(1'b0, 3, e0);
    wait_until(e0 + 1 + 2 * (G + 1));
    #1 reset = 1'b1;
    #1 check_all_zero("midreset");
    check("midreset_queue", exp_q.size(), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    start_seq(1'b0, 5, e0);
    wait_until(e0 + 6 + 4 * G);
    check("replay_link_up", {31'd0, link_up}, 1);
    check("replay_shadow_0", {31'd0, mode_shadow}, 0);
    check("replay_dec_active", {31'd0, dec_active}, 1);
    check("replay_dec_mode", {31'd0, dec_mode}, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
